// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline package for the hazard sequencer.
// Holds register-field and counter widths, the FSM state encodings and the
// operand-forwarding source codes. It has no ports.
package hazard_sequencer_pkg;

    localparam int REG_W = 4;
    localparam int CNT_W = 16;

    // FSM state encodings, as driven on state_o
    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_LSTALL = 2'b01;
    localparam logic [1:0] ST_FLUSH  = 2'b10;
    localparam logic [1:0] ST_MWAIT  = 2'b11;

    // Operand source codes, as driven on fwd_a/fwd_b/fwd_c
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic [1:0] {
        RUN    = ST_RUN,
        LSTALL = ST_LSTALL,
        FLUSH  = ST_FLUSH,
        MWAIT  = ST_MWAIT
    } state_e;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline-to-sequencer bundle.
// slave : the hazard sequencer. It takes the ID/EX/MEM/WB register fields,
//         br_taken and the memory handshake. It drives the forwarding
//         selects, the stage enables and clears, state_o and stall_cnt.
// master: the pipeline side, with the opposite directions.
interface hazard_sequencer_if;
    import hazard_sequencer_pkg::*;

    logic [REG_W-1:0] id_rn, id_rm, id_rd;
    logic             id_use_rn, id_use_rm, id_use_rd;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rf, ex_load;
    logic [REG_W-1:0] mem_rd, wb_rd;
    logic             mem_rf, wb_rf;
    logic             br_taken;
    logic             mem_req, mem_ready;
    logic [1:0]       fwd_a, fwd_b, fwd_c;
    logic             pc_le, ifid_le, idex_le, exmem_le;
    logic             ifid_clr, idex_clr;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               ex_rd, ex_rf, ex_load, mem_rd, wb_rd, mem_rf, wb_rf,
               br_taken, mem_req, mem_ready,
        output fwd_a, fwd_b, fwd_c, pc_le, ifid_le, idex_le, exmem_le,
               ifid_clr, idex_clr, state_o, stall_cnt
    );

    modport master (
        output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               ex_rd, ex_rf, ex_load, mem_rd, wb_rd, mem_rf, wb_rf,
               br_taken, mem_req, mem_ready,
        input  fwd_a, fwd_b, fwd_c, pc_le, ifid_le, idex_le, exmem_le,
               ifid_clr, idex_clr, state_o, stall_cnt
    );

endinterface

// File: rtl/hazard_sequencer_fwd_mux_sel.sv
// Forwarding source select for one ID operand. The logic is combinational.
// Ports:
//   src_i              register field of the operand in ID
//   ex_rd_i/ex_rf_i/ex_load_i, mem_rd_i/mem_rf_i, wb_rd_i/wb_rf_i
//                      destination register and write flags of the later stages
//   sel_o              FWD_RF/FWD_EX/FWD_MEM/FWD_WB
// The youngest matching stage wins. A load in EX has no data yet, so it is
// skipped, and an older stage may supply the value instead.
module fwd_mux_sel
    import hazard_sequencer_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_rf_i,
    input  logic             ex_load_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_rf_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_rf_i,
    output logic [1:0]       sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (ex_rf_i && ex_rd_i == src_i && !ex_load_i) sel_o = FWD_EX;
        else if (mem_rf_i && mem_rd_i == src_i)        sel_o = FWD_MEM;
        else if (wb_rf_i && wb_rd_i == src_i)          sel_o = FWD_WB;
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer.
// Ports:
//   CLK  pipeline clock (rising edge)
//   CLR  asynchronous active-low reset
//   bus  hazard_sequencer_if.slave, which carries the pipeline fields in and
//        the forwarding selects, enables, clears, state_o and stall_cnt out
// The block computes per-operand forwarding selects. A four-state FSM
// arbitrates memory wait, load-use stall and branch flush. A saturating
// counter counts the cycles in which the PC is held.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
(
    input  logic                CLK,
    input  logic                CLR,
    hazard_sequencer_if.slave   bus
);

    localparam int NUM_OPS = 3;

    // Operand forwarding, one selector per ID source field (Rn, Rm, Rd)
    logic [NUM_OPS-1:0][REG_W-1:0] src;
    logic [NUM_OPS-1:0][1:0]       fwd_sel;

    assign src = {bus.id_rd, bus.id_rm, bus.id_rn};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        fwd_mux_sel u_sel (
            .src_i     (src[g]),
            .ex_rd_i   (bus.ex_rd),
            .ex_rf_i   (bus.ex_rf),
            .ex_load_i (bus.ex_load),
            .mem_rd_i  (bus.mem_rd),
            .mem_rf_i  (bus.mem_rf),
            .wb_rd_i   (bus.wb_rd),
            .wb_rf_i   (bus.wb_rf),
            .sel_o     (fwd_sel[g])
        );
    end

    assign bus.fwd_a = fwd_sel[0];
    assign bus.fwd_b = fwd_sel[1];
    assign bus.fwd_c = fwd_sel[2];

    // A hazard is raised only by source fields the ID instruction actually reads
    logic lu, mem_wait;

    assign lu = bus.ex_load && bus.ex_rf &&
                ((bus.id_use_rn && bus.id_rn == bus.ex_rd) ||
                 (bus.id_use_rm && bus.id_rm == bus.ex_rd) ||
                 (bus.id_use_rd && bus.id_rd == bus.ex_rd));
    assign mem_wait = bus.mem_req && !bus.mem_ready;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_le, ifid_le, idex_le, exmem_le, ifid_clr, idex_clr;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // LSTALL and FLUSH only record the previous action. They use the same
    // arbitration as RUN. MWAIT holds everything until memory completes and
    // ignores LU and branches meanwhile.
    always_comb begin
        state_d  = RUN;
        pc_le    = 1'b1;
        ifid_le  = 1'b1;
        idex_le  = 1'b1;
        exmem_le = 1'b1;
        ifid_clr = 1'b0;
        idex_clr = 1'b0;
        if (state_q == MWAIT) begin
            if (!bus.mem_ready) begin
                {pc_le, ifid_le, idex_le, exmem_le} = 4'b0000;
                state_d = MWAIT;
            end
        end else if (mem_wait) begin
            {pc_le, ifid_le, idex_le, exmem_le} = 4'b0000;
            state_d = MWAIT;
        end else if (lu) begin
            // Hold IF/ID and PC. Put a bubble into ID/EX while the load moves on.
            pc_le    = 1'b0;
            ifid_le  = 1'b0;
            idex_clr = 1'b1;
            state_d  = LSTALL;
        end else if (bus.br_taken) begin
            ifid_clr = 1'b1;
            state_d  = FLUSH;
        end
    end

    assign cnt_d = (!pc_le && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    assign bus.pc_le     = pc_le;
    assign bus.ifid_le   = ifid_le;
    assign bus.idex_le   = idex_le;
    assign bus.exmem_le  = exmem_le;
    assign bus.ifid_clr  = ifid_clr;
    assign bus.idex_clr  = idex_clr;
    assign bus.state_o   = state_q;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer. The bench queues expected output
// values when it drives stimulus. It pops and compares them at the next
// falling clock edge, which is away from the active edge.
module tb_hazard_sequencer;

    logic CLK = 1'b0;
    logic CLR;

    hazard_sequencer_if bus ();

    hazard_sequencer dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef enum {O_FA, O_FB, O_FC, O_PC, O_IFID, O_IDEX, O_EXMEM,
                  O_IFCLR, O_IDCLR, O_ST, O_CNT} out_e;
    typedef struct {
        string       tag;
        out_e        sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    function automatic logic [15:0] obs(input out_e s);
        case (s)
            O_FA:    return {14'd0, bus.fwd_a};
            O_FB:    return {14'd0, bus.fwd_b};
            O_FC:    return {14'd0, bus.fwd_c};
            O_PC:    return {15'd0, bus.pc_le};
            O_IFID:  return {15'd0, bus.ifid_le};
            O_IDEX:  return {15'd0, bus.idex_le};
            O_EXMEM: return {15'd0, bus.exmem_le};
            O_IFCLR: return {15'd0, bus.ifid_clr};
            O_IDCLR: return {15'd0, bus.idex_clr};
            O_ST:    return {14'd0, bus.state_o};
            default: return bus.stall_cnt;
        endcase
    endfunction

    task automatic push(input string tag, input out_e sel, input logic [15:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic push_en(input string tag, input logic pc, input logic ifid,
                           input logic idex, input logic exmem);
        push({tag, ".pc_le"},    O_PC,    {15'd0, pc});
        push({tag, ".ifid_le"},  O_IFID,  {15'd0, ifid});
        push({tag, ".idex_le"},  O_IDEX,  {15'd0, idex});
        push({tag, ".exmem_le"}, O_EXMEM, {15'd0, exmem});
    endtask

    task automatic push_clr(input string tag, input logic ifc, input logic idc);
        push({tag, ".ifid_clr"}, O_IFCLR, {15'd0, ifc});
        push({tag, ".idex_clr"}, O_IDCLR, {15'd0, idc});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
    endtask

    // Compare at the falling edge, then move to just after the next rising edge
    task automatic tick();
        @(negedge CLK);
        drain();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.id_rn = 4'd0; bus.id_rm = 4'd0; bus.id_rd = 4'd0;
        bus.id_use_rn = 1'b0; bus.id_use_rm = 1'b0; bus.id_use_rd = 1'b0;
        bus.ex_rd = 4'd15; bus.ex_rf = 1'b0; bus.ex_load = 1'b0;
        bus.mem_rd = 4'd14; bus.mem_rf = 1'b0;
        bus.wb_rd = 4'd13; bus.wb_rf = 1'b0;
        bus.br_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    // Load in EX writing r3 while ID reads r3 through Rn
    task automatic set_lu();
        bus.ex_load = 1'b1; bus.ex_rf = 1'b1; bus.ex_rd = 4'd3;
        bus.id_rn = 4'd3; bus.id_use_rn = 1'b1;
    endtask

    initial begin
        CLR = 1'b0;
        idle();
        #12;
        push("rst.state", O_ST, 16'd0);
        push("rst.cnt", O_CNT, 16'd0);
        push_en("rst", 1, 1, 1, 1);
        push("rst.fwd_a", O_FA, 16'd0);
        drain();
        @(posedge CLK); #1;
        CLR = 1'b1;

        // Forwarding priority
        bus.ex_rd = 4'd5; bus.mem_rd = 4'd5; bus.wb_rd = 4'd5;
        bus.ex_rf = 1'b1; bus.mem_rf = 1'b1; bus.wb_rf = 1'b1;
        bus.id_rn = 4'd5; bus.id_rm = 4'd7; bus.id_rd = 4'd5;
        push("fwd_ex.a", O_FA, 16'd1);
        push("fwd_ex.b", O_FB, 16'd0);
        push("fwd_ex.c", O_FC, 16'd1);
        push("fwd_ex.pc_le", O_PC, 16'd1);
        tick();
        bus.ex_rf = 1'b0;
        push("fwd_mem.a", O_FA, 16'd2);
        tick();
        bus.mem_rf = 1'b0;
        push("fwd_wb.a", O_FA, 16'd3);
        tick();
        bus.wb_rf = 1'b0;
        push("fwd_none.a", O_FA, 16'd0);
        tick();
        bus.ex_rf = 1'b1; bus.mem_rf = 1'b1; bus.ex_load = 1'b1;
        push("fwd_ldskip.a", O_FA, 16'd2);
        push("fwd_ldskip.pc_le", O_PC, 16'd1);
        tick();

        // Load-use through Rm
        idle();
        bus.ex_load = 1'b1; bus.ex_rf = 1'b1; bus.ex_rd = 4'd3;
        bus.id_rm = 4'd3; bus.id_use_rm = 1'b1;
        push_en("lu", 0, 0, 1, 1);
        push_clr("lu", 0, 1);
        push("lu.state", O_ST, 16'd0);
        tick();
        idle();
        push("lu_next.state", O_ST, 16'd1);
        push("lu_next.cnt", O_CNT, 16'd1);
        push_en("lu_next", 1, 1, 1, 1);
        tick();

        // Load-use through the store-data field, then a non-writing load
        bus.ex_load = 1'b1; bus.ex_rf = 1'b1; bus.ex_rd = 4'd9;
        bus.id_rd = 4'd9; bus.id_use_rd = 1'b1;
        push("lu_rd.pc_le", O_PC, 16'd0);
        tick();
        bus.ex_rf = 1'b0;
        push("lu_norf.pc_le", O_PC, 16'd1);
        push("lu_norf.idex_clr", O_IDCLR, 16'd0);
        push("lu_norf.state", O_ST, 16'd1);
        push("lu_norf.cnt", O_CNT, 16'd2);
        tick();

        // Branch, then branch together with load-use
        idle();
        bus.br_taken = 1'b1;
        push_en("br", 1, 1, 1, 1);
        push_clr("br", 1, 0);
        tick();
        idle();
        push("br_next.state", O_ST, 16'd2);
        push("br_next.cnt", O_CNT, 16'd2);
        tick();
        bus.br_taken = 1'b1;
        set_lu();
        push_clr("br_lu", 0, 1);
        push("br_lu.pc_le", O_PC, 16'd0);
        tick();
        idle();
        push("br_lu_next.state", O_ST, 16'd1);
        push("br_lu_next.cnt", O_CNT, 16'd3);
        tick();

        // Reset pulse between edges clears the count
        CLR = 1'b0;
        #2;
        push("rst2.cnt", O_CNT, 16'd0);
        push("rst2.state", O_ST, 16'd0);
        drain();
        @(posedge CLK); #1;
        CLR = 1'b1;

        // Memory wait: one entry cycle plus three MWAIT cycles, then ready
        bus.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus.br_taken = 1'b1;
                set_lu();
            end else begin
                bus.br_taken = 1'b0;
            end
            push_en($sformatf("mw%0d", i), 0, 0, 0, 0);
            push_clr($sformatf("mw%0d", i), 0, 0);
            push($sformatf("mw%0d.state", i), O_ST, (i == 0) ? 16'd0 : 16'd3);
            tick();
        end
        idle();
        bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
        push_en("mw_rdy", 1, 1, 1, 1);
        push("mw_rdy.state", O_ST, 16'd3);
        tick();
        idle();
        push("mw_done.state", O_ST, 16'd0);
        push("mw_done.cnt", O_CNT, 16'd4);
        tick();

        // Asynchronous reset in the middle of MWAIT
        bus.mem_req = 1'b1;
        tick();
        push("mw2.state", O_ST, 16'd3);
        tick();
        #2;
        CLR = 1'b0;
        #1;
        push("arst.state", O_ST, 16'd0);
        push("arst.cnt", O_CNT, 16'd0);
        push("arst.pc_le_memwait", O_PC, 16'd0);
        drain();
        bus.mem_req = 1'b0;
        #1;
        push("arst.pc_le_idle", O_PC, 16'd1);
        drain();
        @(posedge CLK); #1;
        CLR = 1'b1;
        push("arst_rel.state", O_ST, 16'd0);
        push("arst_rel.cnt", O_CNT, 16'd0);
        tick();

        // Saturation under a permanent load-use stall
        set_lu();
        repeat (65534) @(posedge CLK);
        #1;
        push("sat.below", O_CNT, 16'hFFFE);
        drain();
        repeat (3) @(posedge CLK);
        #1;
        push("sat.hold", O_CNT, 16'hFFFF);
        push("sat.state", O_ST, 16'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
